// File: rtl/lsu_load_issue.sv
// Load issue stage: pops the load buffer head, tracks loads in a tag table, issues
// them to the L1D, replays NACKed loads with the same tag and forwards completions.
module lsu_load_issue #(
  parameter  int ADDR_W  = 40,
  parameter  int DATA_W  = 64,
  parameter  int MAX_OUT = 8,
  localparam int TAG_W   = $clog2(MAX_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lb_empty,
  input  logic [ADDR_W-1:0] lb_head_addr,
  output logic              lb_pop,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [TAG_W-1:0]  req_tag,
  input  logic              rsp_valid,
  input  logic [TAG_W-1:0]  rsp_tag,
  input  logic              rsp_nack,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_data,
  output logic [TAG_W:0]    outstanding,
  output logic              err_spurious
);

  logic [MAX_OUT-1:0] valid_q, valid_d;
  logic [MAX_OUT-1:0] replay_q, replay_d;
  logic [ADDR_W-1:0]  addr_q [MAX_OUT];
  logic [ADDR_W-1:0]  addr_d [MAX_OUT];

  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;

  logic              wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_spurious_q, err_spurious_d;

  logic             rep_found, free_found;
  logic [TAG_W-1:0] rep_idx, free_idx;
  logic             slot_free, alloc, rsp_hit;
  logic [TAG_W:0]   valid_count;

  // Lowest-index replay candidate and lowest-index free tag, from registered state only.
  always_comb begin
    rep_found  = 1'b0;
    rep_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (valid_q[i] && replay_q[i]) begin
        rep_found = 1'b1;
        rep_idx   = TAG_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = TAG_W'(i);
      end
    end
  end

  // L1D channel: a request transfers in a cycle where req_valid && req_ready; from the
  // cycle req_valid rises, req_addr/req_tag stay stable until that transfer happens.
  assign slot_free = !req_valid_q || req_ready;
  assign alloc     = slot_free && !rep_found && !lb_empty && free_found;
  assign lb_pop    = alloc && rst_n;
  assign rsp_hit   = rsp_valid && valid_q[rsp_tag];

  always_comb begin
    valid_d     = valid_q;
    replay_d    = replay_q;
    addr_d      = addr_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_tag_d   = req_tag_q;
    if (slot_free) begin
      if (rep_found) begin
        req_valid_d       = 1'b1;
        req_addr_d        = addr_q[rep_idx];
        req_tag_d         = rep_idx;
        replay_d[rep_idx] = 1'b0;
      end else if (alloc) begin
        req_valid_d        = 1'b1;
        req_addr_d         = lb_head_addr;
        req_tag_d          = free_idx;
        valid_d[free_idx]  = 1'b1;
        replay_d[free_idx] = 1'b0;
        addr_d[free_idx]   = lb_head_addr;
      end else begin
        req_valid_d = 1'b0;
      end
    end
    // The allocated tag was free, so a hit can never target it in the same cycle.
    if (rsp_hit) begin
      if (rsp_nack) begin
        replay_d[rsp_tag] = 1'b1;
      end else begin
        valid_d[rsp_tag] = 1'b0;
      end
    end
  end

  always_comb begin
    wb_valid_d     = rsp_hit && !rsp_nack;
    wb_tag_d       = wb_valid_d ? rsp_tag : wb_tag_q;
    wb_data_d      = wb_valid_d ? rsp_data : wb_data_q;
    err_spurious_d = err_spurious_q || (rsp_valid && !valid_q[rsp_tag]);
  end

  always_comb begin
    valid_count = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      valid_count = valid_count + {{TAG_W{1'b0}}, valid_q[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      replay_q       <= '0;
      req_valid_q    <= 1'b0;
      req_addr_q     <= '0;
      req_tag_q      <= '0;
      wb_valid_q     <= 1'b0;
      wb_tag_q       <= '0;
      wb_data_q      <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      replay_q       <= replay_d;
      req_valid_q    <= req_valid_d;
      req_addr_q     <= req_addr_d;
      req_tag_q      <= req_tag_d;
      wb_valid_q     <= wb_valid_d;
      wb_tag_q       <= wb_tag_d;
      wb_data_q      <= wb_data_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  // Entry addresses are only meaningful while valid, so they need no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign req_valid    = req_valid_q;
  assign req_addr     = req_addr_q;
  assign req_tag      = req_tag_q;
  assign wb_valid     = wb_valid_q;
  assign wb_tag       = wb_tag_q;
  assign wb_data      = wb_data_q;
  assign outstanding  = valid_count;
  assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_lsu_load_issue.sv
// Bench for lsu_load_issue: directed scenarios plus randomized traffic, all compared
// against a tag-table reference model and an in-flight response scoreboard.
module tb_lsu_load_issue;

  localparam int ADDR_W  = 40;
  localparam int DATA_W  = 64;
  localparam int MAX_OUT = 8;
  localparam int TAG_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              lb_empty;
  logic [ADDR_W-1:0] lb_head_addr;
  logic              lb_pop;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;
  logic              rsp_valid;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_nack;
  logic [DATA_W-1:0] rsp_data;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic [TAG_W:0]    outstanding;
  logic              err_spurious;

  // clock / reset
  always #5 clk = ~clk;

  lsu_load_issue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .lb_empty(lb_empty), .lb_head_addr(lb_head_addr), .lb_pop(lb_pop),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_nack(rsp_nack), .rsp_data(rsp_data),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pops_seen = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // reference model state
  bit                m_valid  [MAX_OUT];
  bit                m_replay [MAX_OUT];
  logic [ADDR_W-1:0] m_addr   [MAX_OUT];
  bit                m_req_valid;
  logic [ADDR_W-1:0] m_req_addr;
  logic [TAG_W-1:0]  m_req_tag;
  bit                m_wb_valid;
  logic [TAG_W-1:0]  m_wb_tag;
  logic [DATA_W-1:0] m_wb_data;
  bit                m_err;
  int                m_count;

  logic [ADDR_W-1:0] lb_q[$];
  int                inflight_q[$];

  // per-cycle drive values
  bit                d_rdy;
  bit                d_rv;
  logic [TAG_W-1:0]  d_rt;
  bit                d_rn;
  logic [DATA_W-1:0] d_rd;

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[ADDR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MAX_OUT; i++) begin
      m_valid[i]  = 1'b0;
      m_replay[i] = 1'b0;
      m_addr[i]   = '0;
    end
    m_req_valid = 1'b0;
    m_req_addr  = '0;
    m_req_tag   = '0;
    m_wb_valid  = 1'b0;
    m_wb_tag    = '0;
    m_wb_data   = '0;
    m_err       = 1'b0;
    m_count     = 0;
    inflight_q.delete();
  endtask

  task automatic set_rsp(input int tag, input bit nack, input logic [DATA_W-1:0] data);
    int idx[$];
    idx = inflight_q.find_first_index(x) with (x == tag);
    if (idx.size() > 0) inflight_q.delete(idx[0]);
    d_rv = 1'b1;
    d_rt = TAG_W'(tag);
    d_rn = nack;
    d_rd = data;
  endtask

  // driver + scoreboard for one clock cycle
  task automatic cycle();
    bit slot_free, exp_pop, hit;
    int rep, fr;
    @(posedge clk);
    #1;
    req_ready    = d_rdy;
    rsp_valid    = d_rv;
    rsp_tag      = d_rt;
    rsp_nack     = d_rn;
    rsp_data     = d_rd;
    lb_empty     = (lb_q.size() == 0);
    lb_head_addr = (lb_q.size() > 0) ? lb_q[0] : rand_addr();
    @(negedge clk);
    rep = -1;
    fr  = -1;
    for (int i = 0; i < MAX_OUT; i++) if (m_valid[i] && m_replay[i]) begin rep = i; break; end
    for (int i = 0; i < MAX_OUT; i++) if (!m_valid[i]) begin fr = i; break; end
    slot_free = !m_req_valid || d_rdy;
    exp_pop   = slot_free && (rep < 0) && (lb_q.size() > 0) && (m_count < MAX_OUT);
    pops_seen += int'(lb_pop);

    check("req_valid", 64'(req_valid), 64'(m_req_valid));
    if (m_req_valid) begin
      check("req_addr", 64'(req_addr), 64'(m_req_addr));
      check("req_tag", 64'(req_tag), 64'(m_req_tag));
    end
    check("lb_pop", 64'(lb_pop), 64'(exp_pop));
    check("wb_valid", 64'(wb_valid), 64'(m_wb_valid));
    if (m_wb_valid) check("wb_tag", 64'(wb_tag), 64'(m_wb_tag));
    check("wb_data", 64'(wb_data), 64'(m_wb_data));
    check("outstanding", 64'(outstanding), 64'(m_count));
    check("err_spurious", 64'(err_spurious), 64'(m_err));

    hit = d_rv && m_valid[d_rt];
    if (d_rv && !m_valid[d_rt]) m_err = 1'b1;
    if (m_req_valid && d_rdy) inflight_q.push_back(int'(m_req_tag));
    if (slot_free) begin
      if (rep >= 0) begin
        m_req_valid   = 1'b1;
        m_req_addr    = m_addr[rep];
        m_req_tag     = TAG_W'(rep);
        m_replay[rep] = 1'b0;
      end else if (exp_pop) begin
        m_req_valid  = 1'b1;
        m_req_addr   = lb_q[0];
        m_req_tag    = TAG_W'(fr);
        m_valid[fr]  = 1'b1;
        m_replay[fr] = 1'b0;
        m_addr[fr]   = lb_q[0];
        m_count++;
        void'(lb_q.pop_front());
      end else begin
        m_req_valid = 1'b0;
      end
    end
    m_wb_valid = 1'b0;
    if (hit) begin
      if (d_rn) begin
        m_replay[d_rt] = 1'b1;
      end else begin
        m_valid[d_rt] = 1'b0;
        m_count--;
        m_wb_valid = 1'b1;
        m_wb_tag   = d_rt;
        m_wb_data  = d_rd;
      end
    end
    d_rv = 1'b0;
  endtask

  task automatic rand_cycle();
    int k;
    if ($urandom_range(0, 99) < 40 && lb_q.size() < 16) lb_q.push_back(rand_addr());
    d_rdy = ($urandom_range(0, 99) < 70);
    if (inflight_q.size() > 0 && $urandom_range(0, 1) == 1) begin
      k = int'($urandom_range(0, inflight_q.size() - 1));
      set_rsp(inflight_q[k], ($urandom_range(0, 99) < 30), rand_data());
    end
    cycle();
  endtask

  task automatic drain();
    int n = 0;
    d_rdy = 1'b1;
    while ((m_count > 0 || m_req_valid || lb_q.size() > 0) && n < 300) begin
      if (inflight_q.size() > 0) set_rsp(inflight_q[0], 1'b0, rand_data());
      cycle();
      n++;
    end
    cycle();
    check("drain_outstanding", 64'(outstanding), 64'(0));
    check("drain_req_valid", 64'(req_valid), 64'(0));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_valid"}, 64'(req_valid), 64'(0));
    check({pfx, "_req_addr"}, 64'(req_addr), 64'(0));
    check({pfx, "_req_tag"}, 64'(req_tag), 64'(0));
    check({pfx, "_lb_pop"}, 64'(lb_pop), 64'(0));
    check({pfx, "_wb_valid"}, 64'(wb_valid), 64'(0));
    check({pfx, "_wb_tag"}, 64'(wb_tag), 64'(0));
    check({pfx, "_wb_data"}, 64'(wb_data), 64'(0));
    check({pfx, "_outstanding"}, 64'(outstanding), 64'(0));
    check({pfx, "_err"}, 64'(err_spurious), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    lb_empty = 1'b1; lb_head_addr = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_tag = '0; rsp_nack = 1'b0; rsp_data = '0;
    d_rdy = 1'b0; d_rv = 1'b0; d_rt = '0; d_rn = 1'b0; d_rd = '0;
    model_reset();
    #2;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single load
    lb_q.push_back(40'h00_1000_0040);
    d_rdy = 1'b1;
    cycle();
    check("t1_pop", 64'(lb_pop), 64'(1));
    cycle();
    check("t1_req_valid", 64'(req_valid), 64'(1));
    check("t1_req_addr", 64'(req_addr), 64'h00_1000_0040);
    check("t1_req_tag", 64'(req_tag), 64'(0));
    set_rsp(0, 1'b0, 64'hDEAD_BEEF_0000_0001);
    cycle();
    cycle();
    check("t1_wb_valid", 64'(wb_valid), 64'(1));
    check("t1_wb_tag", 64'(wb_tag), 64'(0));
    check("t1_wb_data", 64'(wb_data), 64'hDEAD_BEEF_0000_0001);
    check("t1_outstanding", 64'(outstanding), 64'(0));
    drain();

    // backpressure
    for (int i = 0; i < 3; i++) lb_q.push_back(40'h00_2000_0000 + 40'(i * 8));
    d_rdy = 1'b0;
    p0 = pops_seen;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i > 0) begin
        check("t2_hold_addr", 64'(req_addr), 64'h00_2000_0000);
        check("t2_hold_tag", 64'(req_tag), 64'(0));
      end
    end
    check("t2_stall_pops", 64'(pops_seen - p0), 64'(1));
    d_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t2_issue_valid", 64'(req_valid), 64'(1));
      check("t2_issue_tag", 64'(req_tag), 64'(i));
    end
    drain();

    // full table
    for (int i = 0; i < 10; i++) lb_q.push_back(40'h00_4000_0000 + 40'(i * 64));
    d_rdy = 1'b1;
    p0 = pops_seen;
    repeat (12) cycle();
    check("t3_pops", 64'(pops_seen - p0), 64'(8));
    check("t3_outstanding", 64'(outstanding), 64'(8));
    check("t3_full_no_pop", 64'(lb_pop), 64'(0));
    set_rsp(3, 1'b0, rand_data());
    cycle();
    check("t3_no_early_pop", 64'(lb_pop), 64'(0));
    cycle();
    check("t3_pop_after_free", 64'(lb_pop), 64'(1));
    cycle();
    check("t3_reuse_tag", 64'(req_tag), 64'(3));
    check("t3_reuse_addr", 64'(req_addr), 64'h00_4000_0200);
    drain();

    // NACK replay ahead of a pending new load
    for (int i = 0; i < 4; i++) lb_q.push_back(40'h00_5000_0000 + 40'(i * 16));
    d_rdy = 1'b1;
    repeat (3) cycle();
    d_rdy = 1'b0;
    set_rsp(1, 1'b1, rand_data());
    cycle();
    d_rdy = 1'b1;
    cycle();
    check("t4_replay_no_pop", 64'(lb_pop), 64'(0));
    cycle();
    check("t4_replay_valid", 64'(req_valid), 64'(1));
    check("t4_replay_tag", 64'(req_tag), 64'(1));
    check("t4_replay_addr", 64'(req_addr), 64'h00_5000_0010);
    set_rsp(1, 1'b0, 64'h0123_4567_89AB_CDEF);
    cycle();
    cycle();
    check("t4_wb_valid", 64'(wb_valid), 64'(1));
    check("t4_wb_tag", 64'(wb_tag), 64'(1));
    check("t4_wb_data", 64'(wb_data), 64'h0123_4567_89AB_CDEF);
    drain();

    // randomized traffic
    repeat (1500) rand_cycle();
    drain();

    // spurious response
    d_rv = 1'b1; d_rt = 3'd5; d_rn = 1'b0; d_rd = rand_data();
    cycle();
    cycle();
    check("t5_no_wb", 64'(wb_valid), 64'(0));
    check("t5_err_set", 64'(err_spurious), 64'(1));
    repeat (3) cycle();
    check("t5_err_sticky", 64'(err_spurious), 64'(1));

    // reset mid-operation
    for (int i = 0; i < 4; i++) lb_q.push_back(40'h00_6000_0000 + 40'(i * 32));
    d_rdy = 1'b1;
    repeat (4) cycle();
    d_rdy = 1'b0;
    cycle();
    check("t6_pre_outstanding", 64'(outstanding), 64'(4));
    check("t6_pre_req_valid", 64'(req_valid), 64'(1));
    #1;
    rst_n = 1'b0;
    lb_empty = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    model_reset();
    lb_q.delete();
    d_rv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lb_q.push_back(40'h00_3000_0100);
    d_rdy = 1'b1;
    cycle();
    check("t6_post_pop", 64'(lb_pop), 64'(1));
    cycle();
    check("t6_post_tag", 64'(req_tag), 64'(0));
    check("t6_post_addr", 64'(req_addr), 64'h00_3000_0100);

    repeat (800) rand_cycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_load_issue.md
Name: lsu_load_issue

Overview:
- Downstream consumer of the SM LSU load buffer. Pops the buffer head and issues tagged load requests to the L1D over a valid/ready channel.
- Tracks up to MAX_OUT outstanding loads in a tag table.
- Replays requests the L1D NACKs, using the same tag.
- Returns completed load data to register writeback on a tagged, non-backpressured channel.

Parameters:
- ADDR_W, 40, load address width; matches the load buffer.
- DATA_W, 64, load data width.
- MAX_OUT, 8, outstanding-load tag table entries; power of 2, at least 2.
- TAG_W, $clog2(MAX_OUT), tag width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lb_empty  in  1  load buffer empty
- lb_head_addr  in  ADDR_W  load buffer head address
- lb_pop  out  1  consume load buffer head (1-cycle pulse)
- req_valid  out  1  L1D request valid
- req_ready  in  1  L1D accepts the request
- req_addr  out  ADDR_W  request address
- req_tag  out  TAG_W  request tag
- rsp_valid  in  1  L1D response valid
- rsp_tag  in  TAG_W  response tag
- rsp_nack  in  1  1 = miss/bank conflict, replay required
- rsp_data  in  DATA_W  load data
- wb_valid  out  1  writeback valid
- wb_tag  out  TAG_W  writeback tag
- wb_data  out  DATA_W  writeback data
- outstanding  out  TAG_W+1  count of allocated tags
- err_spurious  out  1  sticky: a response arrived for an unallocated tag

Behaviour:
- Reset, asynchronous: tag table valid/replay bits = 0; req_valid = 0; req_addr/req_tag = 0; wb_valid/wb_tag/wb_data = 0; lb_pop = 0; outstanding = 0; err_spurious = 0. Reset mid-operation drops all in-flight loads. L1D responses arriving after reset are spurious.
- Tag table: per entry, valid, replay, and addr (ADDR_W).
- Request register (slot):
  - req_* are registered outputs.
  - Once req_valid = 1, req_addr and req_tag hold until req_valid && req_ready.
  - The slot may load in a cycle when it is empty, or when its current request is accepted that cycle (back-to-back issue, 1 req/cycle).
- Slot load priority:
  1. Replay: the lowest-index entry with valid = 1 and replay = 1. Load req_addr = entry addr, req_tag = index; clear that entry's replay bit. No pop.
  2. New load: only when lb_empty = 0 and a free tag exists (lowest-index entry with valid = 0, evaluated on registered state). Load req_addr = lb_head_addr, req_tag = free index; set valid = 1, addr = lb_head_addr; assert lb_pop combinationally in that same cycle.
  3. Otherwise the slot goes empty (req_valid = 0).
- lb_pop is asserted only when a new load is captured. It is never asserted when lb_empty = 1.
- A tag freed by a response in cycle N is not allocatable until cycle N+1.
- Response handling, when rsp_valid = 1:
  - Tag not valid in the table: ignore; set err_spurious = 1 (cleared only by reset).
  - rsp_nack = 1: set the entry's replay bit. Valid stays 1; the tag is reused on replay.
  - rsp_nack = 0: in cycle N+1, wb_valid = 1, wb_tag = rsp_tag, wb_data = rsp_data. Clear the entry's valid bit at the end of cycle N. wb_valid is a 1-cycle pulse per response.
  - wb_data holds its last value when wb_valid = 0.
- A response may arrive for a tag that is currently in the slot awaiting replay. This is impossible by protocol; the behaviour is unspecified.
- outstanding = popcount(valid). It includes entries that are replaying or sitting in the slot.
- Full condition: outstanding == MAX_OUT. No new issue and no lb_pop until a tag frees. Replays still issue.
- Empty condition: lb_empty = 1 with no replays pending. req_valid drops after the current request is accepted.
- Simultaneous allocate and free of different tags in one cycle: outstanding is unchanged.
- Simultaneous NACK and replay selection in one cycle: the NACKed entry becomes eligible the next cycle.

Test Plan:
- Single load: head 0x00_1000_0040, req_ready = 1 → lb_pop pulse; next cycle req_valid = 1, addr 0x00_1000_0040, tag 0. rsp tag 0, data 0xDEAD_BEEF_0000_0001 → wb_valid one cycle later with tag 0 and that data; outstanding returns to 0.
- Backpressure: req_ready = 0 for 5 cycles with 3 loads queued → req_addr/req_tag stable, exactly 1 lb_pop during the stall; after release, tags 0, 1, 2 issue on consecutive cycles.
- Full table: MAX_OUT = 8, 10 loads queued, no responses → 8 pops, outstanding = 8, lb_pop stays 0. Respond tag 3 → next new load gets tag 3 no earlier than the following cycle.
- NACK replay: issue tags 0 and 1; NACK tag 1 → req reissues addr of tag 1 with tag 1 ahead of a pending new load. Second response for tag 1 with nack = 0 → wb_tag = 1.
- Spurious response: rsp_valid with tag 5 when idle → no wb_valid, err_spurious = 1 and stays 1.
- Reset mid-operation: 4 outstanding plus req_valid = 1, assert rst_n low → all outputs at reset values immediately; after release, first new load gets tag 0.
